ofdm_tx_add_cp: RTL and testbench
=================================

// Module: ofdm_tx_add_cp
// PURPOSE
//  Transmit-side cyclic-prefix insertion for the 802.22 OFDM chain; the TX counterpart of the RX CP-removal stage.
//  Buffers one NFFT-sample IFFT output symbol from the upstream Wishbone-style stream.
//  Replays the last Ncp samples, then all NFFT samples, on the downstream stream. Ncp = NFFT>>(2+CP_SEL).
//  Sits between the TX IFFT and the DAC/RX-loopback interface.
// PARAMETERS
//  NFFT    2048  samples per OFDM symbol (power of 2)
//  LOG2N   11    log2(NFFT); counter/address width
//  DW      32    sample width, {Q[31:16], I[15:0]}, two's complement
// PORTS
//  CLK_I   in   1    single clock, all logic on rising edge
//  RST_I   in   1    asynchronous, active-low reset
//  CP_SEL  in   2    CP ratio 0:1/4 1:1/8 2:1/16 3:1/32; latched at frame start
//  DAT_I   in   DW   upstream sample
//  CYC_I   in   1    upstream frame active
//  STB_I   in   1    upstream sample valid
//  WE_I    in   1    upstream write strobe (must be 1 with STB_I; ignored otherwise)
//  ACK_O   out  1    upstream accept, combinational
//  DAT_O   out  DW   downstream sample
//  CYC_O   out  1    downstream frame active
//  STB_O   out  1    downstream sample valid
//  WE_O    out  1    equals STB_O
//  ACK_I   in   1    downstream accept
// BEHAVIOUR
//  Reset: CYC_O=STB_O=WE_O=0, DAT_O=0, ACK_O=0, state=IDLE, counters=0, latched CP=1/4. Async reset mid-symbol aborts; buffered data is lost.
//  Transfers: in = CYC_I&STB_I&ACK_O at posedge; out = STB_O&ACK_I at posedge.
//  ACK_O = CYC_I & STB_I & (state==IDLE | state==FILL); never asserted while emitting.
//  FSM:
//   IDLE: on input transfer, write mem[0], wr_cnt=1, latch CP_SEL -> FILL.
//   FILL: each transfer writes mem[wr_cnt], wr_cnt++.
//     Transfer at wr_cnt==NFFT-1 -> CP, rd_addr=NFFT-Ncp.
//     CYC_I low with partial symbol: discard it -> IDLE; no output emitted.
//   CP: emit mem[NFFT-Ncp..NFFT-1]; after Ncp output transfers -> SYM, rd_addr=0.
//   SYM: emit mem[0..NFFT-1]; after NFFT-th output transfer:
//     -> FILL (wr_cnt=0) if CYC_I=1; -> IDLE otherwise.
//  CP_SEL is re-latched only in IDLE; changes within a frame are ignored.
//  Latency: STB_O rises on the 2nd rising edge after the last input transfer (RAM read + output register).
//  Stall: while STB_O & ~ACK_I, DAT_O and STB_O hold stable; the read pipeline advances only when ~STB_O | ACK_I.
//  STB_O is continuous (no bubbles) while ACK_I=1: each symbol is NFFT+Ncp back-to-back outputs.
//  CYC_O rises with the first STB_O of a frame.
//   It falls the cycle after the last output of a symbol when the FSM enters IDLE.
//   It stays high across FILL between symbols of one frame.
//  Address arithmetic is modulo 2^LOG2N; NFFT-Ncp never wraps for legal CP_SEL.
//  Simultaneous CYC_I drop and final output transfer: take the IDLE path, CYC_O falls next cycle.
// STRUCTURE
//  Shared include ofdm_802_22_params.vh: NFFT, LOG2N, CP_SEL encodings, Ncp table, FSM state localparams.
//  Sub-module ofdm_sym_ram: simple dual-port NFFT x DW RAM; sync write, sync read with read-enable.
//  Remaining logic (FSM, counters, output register) stays in this module.
// TESTING
//  1 Ramp: ramp 0..2047 as I, Q=~I, CP_SEL=0, ACK_I=1 -> 2560 outputs: I=1536..2047, then I=0..2047; CYC_O falls after the last.
//  2 Frame: 3 symbols in one CYC_I frame, CP_SEL=3
//    -> 3x2112 outputs, each starting I=1984.
//    -> CYC_O high throughout and falls once; ACK_O=0 during every emit phase.
//  3 Stall: random ACK_I (50%), CP_SEL=1 -> output sequence identical to test 1 order with Ncp=256; DAT_O stable on every stalled cycle.
//  4 Abort: drop CYC_I after 1000 inputs -> no STB_O; next full symbol with CP_SEL=2 emits 2048+128 correct samples.
//  5 Reset: assert RST_I low mid-CP phase -> all outputs 0 within the same cycle; a clean symbol afterwards matches test 1.
//  6 CP_SEL change mid-frame (0->2 after symbol 1) -> both symbols use Ncp=512.

Source files
------------

// File: rtl/ofdm_tx_add_cp_pkg.sv
// Shared definitions for the TX cyclic-prefix insertion block.
//   NFFT / LOG2N / DW : symbol length, address width, sample width
//   CP_* encodings    : CP_SEL values (CP length = NFFT >> (2 + CP_SEL))
//   state_t           : FSM states, also exported on the debug port
//   cp_len()          : CP length for a CP_SEL code
package ofdm_tx_add_cp_pkg;

  localparam int NFFT  = 2048;
  localparam int LOG2N = 11;
  localparam int DW    = 32;

  localparam logic [1:0] CP_1_4  = 2'd0;
  localparam logic [1:0] CP_1_8  = 2'd1;
  localparam logic [1:0] CP_1_16 = 2'd2;
  localparam logic [1:0] CP_1_32 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_CP   = 2'd2,
    ST_SYM  = 2'd3
  } state_t;

  // CP length in samples; one bit wider than an address so NFFT fits.
  function automatic logic [LOG2N:0] cp_len(input logic [1:0] sel);
    logic [LOG2N:0] n;
    case (sel)
      CP_1_4:  n = (LOG2N+1)'(NFFT / 4);
      CP_1_8:  n = (LOG2N+1)'(NFFT / 8);
      CP_1_16: n = (LOG2N+1)'(NFFT / 16);
      default: n = (LOG2N+1)'(NFFT / 32);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ofdm_tx_add_cp_if.sv
// Wishbone-style sample stream between OFDM stages.
//   dat : sample {Q[31:16], I[15:0]}
//   cyc : frame active
//   stb : sample valid (source side)
//   we  : write strobe, equals stb on a well-formed source
//   ack : accept (sink side)
// Handshake: a sample moves on a rising edge where cyc & stb & ack are all 1.
// While stb is high and ack is low the source holds dat and stb stable; the
// sink may raise or drop ack freely, and ack may depend combinationally on stb.
interface ofdm_tx_add_cp_if;

  logic [ofdm_tx_add_cp_pkg::DW-1:0] dat;
  logic                               cyc;
  logic                               stb;
  logic                               we;
  logic                               ack;

  modport master (output dat, cyc, stb, we, input ack);
  modport slave  (input dat, cyc, stb, we, output ack);

endinterface

// File: rtl/ofdm_tx_add_cp_sym_ram.sv
// Simple dual-port NFFT x DW symbol buffer.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr     : synchronous read port; rdata updates only when re=1 and
//                  otherwise holds, which lets the caller stall the read stage
//   rdata        : registered read data
module ofdm_tx_add_cp_sym_ram
  import ofdm_tx_add_cp_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [LOG2N-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [NFFT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ofdm_tx_add_cp.sv
// Transmit-side cyclic-prefix insertion.
// Buffers one NFFT-sample IFFT symbol from the upstream stream, then replays
// the last Ncp samples followed by all NFFT samples downstream.
//   CLK_I     : clock, rising edge
//   RST_I     : asynchronous reset, active low
//   CP_SEL    : CP ratio code, latched when a frame starts (FSM in IDLE)
//   up        : upstream stream (this block is the sink)
//   down      : downstream stream (this block is the source)
//   dbg_state : current FSM state
module ofdm_tx_add_cp
  import ofdm_tx_add_cp_pkg::*;
(
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [1:0]            CP_SEL,
  ofdm_tx_add_cp_if.slave       up,
  ofdm_tx_add_cp_if.master      down,
  output state_t                dbg_state
);

  localparam logic [LOG2N:0]   NFFT_W = (LOG2N+1)'(NFFT);
  localparam logic [LOG2N-1:0] LAST_A = LOG2N'(NFFT - 1);

  state_t           state;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_addr;
  logic [LOG2N:0]   rd_cnt;   // reads issued in the current CP or SYM phase
  logic [1:0]       cp_sel_q;
  logic [LOG2N:0]   ncp;
  logic             rd_v;     // RAM read register holds a sample not yet output
  logic             stb_q;
  logic             cyc_q;
  logic [DW-1:0]    dat_q;
  logic [DW-1:0]    ram_q;

  logic             in_xfer;
  logic             adv;
  logic             issue;
  logic             last_out;

  assign ncp = cp_len(cp_sel_q);

  // Accept only while collecting a symbol; reset forces ack low immediately.
  assign up.ack  = RST_I & up.cyc & up.stb & ((state == ST_IDLE) || (state == ST_FILL));
  assign in_xfer = up.cyc & up.stb & up.ack;

  // The two-stage read pipeline (RAM register, output register) moves as a
  // unit whenever the output register is empty or being drained.
  assign adv   = ~stb_q | down.ack;
  assign issue = adv & ((state == ST_CP) || ((state == ST_SYM) && (rd_cnt != NFFT_W)));

  // All NFFT symbol reads issued and the RAM stage is empty, so this output
  // transfer is the final sample of the symbol.
  assign last_out = stb_q & down.ack & ~rd_v & (state == ST_SYM) & (rd_cnt == NFFT_W);

  ofdm_tx_add_cp_sym_ram u_ram (
    .clk   (CLK_I),
    .we    (in_xfer),
    .waddr (wr_cnt),
    .wdata (up.dat),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= ST_IDLE;
      wr_cnt   <= '0;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      cp_sel_q <= CP_1_4;
      rd_v     <= 1'b0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      if (adv) begin
        stb_q <= rd_v;
        rd_v  <= issue;
        if (rd_v) begin
          dat_q <= ram_q;
          cyc_q <= 1'b1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (in_xfer) begin
            wr_cnt   <= LOG2N'(1);
            cp_sel_q <= CP_SEL;
            state    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (in_xfer) begin
            if (wr_cnt == LAST_A) begin
              wr_cnt  <= '0;
              rd_cnt  <= '0;
              rd_addr <= LOG2N'(NFFT_W - ncp);
              state   <= ST_CP;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end else if (!up.cyc) begin
            // Frame ended with a partial (or no) symbol: drop it.
            wr_cnt <= '0;
            cyc_q  <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_CP: begin
          if (issue) begin
            if (rd_cnt == ncp - 1'b1) begin
              rd_cnt  <= '0;
              rd_addr <= '0;
              state   <= ST_SYM;
            end else begin
              rd_cnt  <= rd_cnt + 1'b1;
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end

        ST_SYM: begin
          if (issue) begin
            rd_cnt  <= rd_cnt + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end
          if (last_out) begin
            rd_cnt  <= '0;
            rd_addr <= '0;
            if (up.cyc) begin
              state <= ST_FILL;
            end else begin
              cyc_q <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign down.dat  = dat_q;
  assign down.stb  = stb_q;
  assign down.we   = stb_q;
  assign down.cyc  = cyc_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ofdm_tx_add_cp.sv
// Directed testbench for ofdm_tx_add_cp.
module tb_ofdm_tx_add_cp;
  import ofdm_tx_add_cp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [1:0] cp_sel;
  state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ofdm_tx_add_cp_if up_if ();
  ofdm_tx_add_cp_if dn_if ();

  ofdm_tx_add_cp dut (
    .CLK_I     (clk),
    .RST_I     (rst_n),
    .CP_SEL    (cp_sel),
    .up        (up_if),
    .down      (dn_if),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_log[$];
  int n_checks;
  int n_pass;
  int stb_seen;
  int stalls;
  int cyc_falls;
  bit rand_ack;
  bit stall_pend;
  bit prev_cyc;
  logic [DW-1:0] held_dat;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sample word: I = index, Q = ~I xor symbol id (symbol 0 gives Q = ~I).
  function automatic logic [DW-1:0] mk(input int sym, input int i);
    logic [15:0] iv;
    iv = 16'(i);
    return {~iv ^ 16'(sym), iv};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [DW-1:0] d);
    int t;
    t = 0;
    up_if.cyc = 1'b1;
    up_if.stb = 1'b1;
    up_if.we  = 1'b1;
    up_if.dat = d;
    @(negedge clk);
    while (!up_if.ack && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!up_if.ack) begin
      check("push_ack_timeout", up_if.ack, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_symbol(input int sym, input int n);
    for (int i = 0; i < n; i++) push(mk(sym, i));
  endtask

  task automatic end_frame();
    up_if.cyc = 1'b0;
    up_if.stb = 1'b0;
    up_if.we  = 1'b0;
  endtask

  task automatic load_exp(input int sym, input int ncp_len);
    for (int i = NFFT - ncp_len; i < NFFT; i++) exp_q.push_back(mk(sym, i));
    for (int i = 0; i < NFFT; i++) exp_q.push_back(mk(sym, i));
  endtask

  task automatic start_test();
    out_log.delete();
    cyc_falls = 0;
    stb_seen  = 0;
    stalls    = 0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_left", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    check("cyc_o_low_after", dn_if.cyc, 1'b0);
    check("idle_after", dbg_state, ST_IDLE);
  endtask

  task automatic check_i(input string tag, input int idx, input int exp_i);
    if (idx < out_log.size()) check(tag, out_log[idx][15:0], 16'(exp_i));
    else check(tag, out_log.size(), idx + 1);
  endtask

  // ---------------- random ack for stall test ----------------
  always @(posedge clk) begin
    #1;
    if (rand_ack) dn_if.ack = 1'($urandom_range(0, 1));
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
      prev_cyc   = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_hold_stb", dn_if.stb, 1'b1);
        check("stall_hold_dat", dn_if.dat, held_dat);
        stalls++;
      end
      if (dn_if.stb) begin
        stb_seen++;
        check("ack_o_quiet", up_if.ack, 1'b0);
        if (dn_if.ack) begin
          check("exp_avail", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("dout", dn_if.dat, exp_q.pop_front());
          out_log.push_back(dn_if.dat);
        end
      end
      if (!prev_cyc && dn_if.cyc) check("cyc_rise_with_stb", dn_if.stb, 1'b1);
      if (prev_cyc && !dn_if.cyc) cyc_falls++;
      prev_cyc   = dn_if.cyc;
      stall_pend = dn_if.stb & ~dn_if.ack;
      held_dat   = dn_if.dat;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rand_ack = 1'b0;
    rst_n    = 1'b0;
    cp_sel   = 2'd0;
    up_if.cyc = 1'b0;
    up_if.stb = 1'b0;
    up_if.we  = 1'b0;
    up_if.dat = '0;
    dn_if.ack = 1'b1;
    start_test();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", dn_if.stb, 1'b0);
    check("rst_cyc", dn_if.cyc, 1'b0);
    check("rst_we", dn_if.we, 1'b0);
    check("rst_dat", dn_if.dat, 32'h0);
    check("rst_ack", up_if.ack, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: ramp, CP 1/4 -> I=1536..2047 then 0..2047
    start_test();
    cp_sel = 2'd0;
    load_exp(0, 512);
    send_symbol(0, NFFT);
    end_frame();
    check("t1_state_cp", dbg_state, ST_CP);
    @(posedge clk);
    #1;
    check("t1_lat_e1_stb", dn_if.stb, 1'b0);
    @(posedge clk);
    #1;
    check("t1_lat_e2_stb", dn_if.stb, 1'b1);
    check("t1_first_dat", dn_if.dat, 32'hF9FF_0600);
    check("t1_we", dn_if.we, 1'b1);
    check("t1_cyc", dn_if.cyc, 1'b1);
    wait_drain();
    check("t1_count", out_log.size(), 2560);
    check_i("t1_i_511", 511, 2047);
    check_i("t1_i_512", 512, 0);
    check_i("t1_i_last", 2559, 2047);
    check("t1_cyc_falls", cyc_falls, 1);

    // Test 2: three symbols in one frame, CP 1/32
    start_test();
    cp_sel = 2'd3;
    for (int s = 1; s <= 3; s++) begin
      load_exp(s, 64);
      send_symbol(s, NFFT);
    end
    end_frame();
    wait_drain();
    check("t2_count", out_log.size(), 3 * 2112);
    check_i("t2_first_0", 0, 1984);
    check_i("t2_first_1", 2112, 1984);
    check_i("t2_first_2", 4224, 1984);
    check("t2_cyc_falls", cyc_falls, 1);

    // Test 3: random downstream stalls, CP 1/8
    start_test();
    cp_sel = 2'd1;
    rand_ack = 1'b1;
    load_exp(0, 256);
    send_symbol(0, NFFT);
    end_frame();
    wait_drain();
    rand_ack = 1'b0;
    @(posedge clk);
    #2;
    dn_if.ack = 1'b1;
    check("t3_count", out_log.size(), 2304);
    check_i("t3_first", 0, 1792);
    check("t3_stalls_seen", stalls > 0, 1'b1);

    // Test 4: partial symbol aborted, then full symbol with CP 1/16
    start_test();
    cp_sel = 2'd2;
    send_symbol(5, 1000);
    end_frame();
    repeat (20) @(posedge clk);
    #1;
    check("t4_abort_idle", dbg_state, ST_IDLE);
    check("t4_no_stb", stb_seen, 0);
    check("t4_no_cyc", dn_if.cyc, 1'b0);
    load_exp(6, 128);
    send_symbol(6, NFFT);
    end_frame();
    wait_drain();
    check("t4_count", out_log.size(), 2176);
    check_i("t4_first", 0, 1920);

    // Test 5: reset during CP emission, then a clean symbol
    start_test();
    cp_sel = 2'd0;
    load_exp(7, 512);
    send_symbol(7, NFFT);
    end_frame();
    repeat (100) @(posedge clk);
    #1;
    check("t5_in_cp", dbg_state, ST_CP);
    up_if.cyc = 1'b1;
    up_if.stb = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_stb", dn_if.stb, 1'b0);
    check("t5_rst_cyc", dn_if.cyc, 1'b0);
    check("t5_rst_we", dn_if.we, 1'b0);
    check("t5_rst_dat", dn_if.dat, 32'h0);
    check("t5_rst_ack", up_if.ack, 1'b0);
    check("t5_rst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    end_frame();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_test();
    load_exp(0, 512);
    send_symbol(0, NFFT);
    end_frame();
    wait_drain();
    check("t5_count", out_log.size(), 2560);
    check_i("t5_first", 0, 1536);
    check_i("t5_i_512", 512, 0);

    // Test 6: CP_SEL changes mid-frame and is ignored
    start_test();
    cp_sel = 2'd0;
    load_exp(8, 512);
    send_symbol(8, NFFT);
    cp_sel = 2'd2;
    load_exp(9, 512);
    send_symbol(9, NFFT);
    end_frame();
    wait_drain();
    check("t6_count", out_log.size(), 2 * 2560);
    check_i("t6_first_0", 0, 1536);
    check_i("t6_first_1", 2560, 1536);
    check("t6_cyc_falls", cyc_falls, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
